// File: rtl/puf_race_ctrl.sv
// puf_race_ctrl: measurement sequencer for a two-counter ring-oscillator PUF.
// For each response bit it selects an RO pair, enables both counters, and
// records which counter reports o_valid first. The assembled word is offered
// to the host over a valid/ready handshake. Ties and timeouts raise sticky
// error flags that are cleared when the next measurement is accepted.
module puf_race_ctrl #(
  parameter int RESP_BITS   = 8,
  parameter int SEL_W       = 3,
  parameter int TIMEOUT_CYC = 1024,
  parameter int GAP_CYC     = 4,
  parameter int TMR_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_cnt_en,
  output logic [SEL_W-1:0]     o_pair_sel,
  input  logic                 i_valid_a,
  input  logic                 i_valid_b,
  output logic [RESP_BITS-1:0] o_resp,
  output logic                 o_resp_valid,
  input  logic                 i_resp_ready,
  output logic                 o_tie_err,
  output logic                 o_timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Terminal counts, sized to the counters they are compared against.
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYC - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(RESP_BITS - 1);

  state_t             state_r;
  logic [SEL_W-1:0]   idx_r;
  logic [TMR_W-1:0]   timer_r;

  logic               decide_s;
  logic               bit_s;
  logic               tie_s;
  logic               tout_s;

  // The bit index is itself a register, so the pair select stays registered.
  assign o_pair_sel = idx_r;

  // Race decision for the current ARM cycle; a valid pulse always beats the timeout.
  always_comb begin
    decide_s = 1'b0;
    bit_s    = 1'b0;
    tie_s    = 1'b0;
    tout_s   = 1'b0;
    if (state_r == ARM) begin
      if (i_valid_a || i_valid_b) begin
        decide_s = 1'b1;
        bit_s    = i_valid_a & ~i_valid_b;
        tie_s    = i_valid_a & i_valid_b;
      end else if (timer_r == TMO_LAST) begin
        decide_s = 1'b1;
        tout_s   = 1'b1;
      end else begin
        decide_s = 1'b0;
      end
    end else begin
      decide_s = 1'b0;
    end
  end

  // Sequencer state machine with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      idx_r         <= {SEL_W{1'b0}};
      timer_r       <= {TMR_W{1'b0}};
      o_busy        <= 1'b0;
      o_cnt_en      <= 1'b0;
      o_resp        <= {RESP_BITS{1'b0}};
      o_resp_valid  <= 1'b0;
      o_tie_err     <= 1'b0;
      o_timeout_err <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_start) begin
            state_r       <= ARM;
            idx_r         <= {SEL_W{1'b0}};
            timer_r       <= {TMR_W{1'b0}};
            o_busy        <= 1'b1;
            o_cnt_en      <= 1'b1;
            o_resp        <= {RESP_BITS{1'b0}};
            o_tie_err     <= 1'b0;
            o_timeout_err <= 1'b0;
          end
        end
        ARM: begin
          if (decide_s) begin
            o_resp[idx_r] <= bit_s;
            o_tie_err     <= o_tie_err | tie_s;
            o_timeout_err <= o_timeout_err | tout_s;
            o_cnt_en      <= 1'b0;
            timer_r       <= {TMR_W{1'b0}};
            state_r       <= GAP;
          end else begin
            timer_r <= timer_r + TMR_W'(1);
          end
        end
        GAP: begin
          // Enable stays low long enough for both counters to clear.
          if (timer_r == GAP_LAST) begin
            timer_r <= {TMR_W{1'b0}};
            if (idx_r == IDX_LAST) begin
              state_r      <= DONE;
              o_resp_valid <= 1'b1;
            end else begin
              idx_r    <= idx_r + SEL_W'(1);
              o_cnt_en <= 1'b1;
              state_r  <= ARM;
            end
          end else begin
            timer_r <= timer_r + TMR_W'(1);
          end
        end
        DONE: begin
          if (i_resp_ready) begin
            state_r      <= IDLE;
            o_resp_valid <= 1'b0;
            o_busy       <= 1'b0;
          end
        end
        default: begin
          state_r      <= IDLE;
          timer_r      <= {TMR_W{1'b0}};
          o_busy       <= 1'b0;
          o_cnt_en     <= 1'b0;
          o_resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_race_ctrl.sv
// Testbench for puf_race_ctrl: directed race patterns, scoreboard-checked
// responses, enable-gap and latency checks, reset, backpressure and stray pulses.
module tb_puf_race_ctrl;

  localparam int GAP_N = 4;
  localparam int TMO_N = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       i_start = 1'b0;
  logic       i_valid_a = 1'b0;
  logic       i_valid_b = 1'b0;
  logic       i_resp_ready = 1'b1;
  logic       o_busy;
  logic       o_cnt_en;
  logic [2:0] o_pair_sel;
  logic [7:0] o_resp;
  logic       o_resp_valid;
  logic       o_tie_err;
  logic       o_timeout_err;

  typedef struct packed {
    logic [7:0] resp;
    logic       tie;
    logic       tout;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   hs_count = 0;
  int   push_count = 0;
  bit   gap_seen_high = 1'b0;
  int   gap_run = 0;

  puf_race_ctrl #(
    .RESP_BITS(8), .SEL_W(3), .TIMEOUT_CYC(TMO_N), .GAP_CYC(GAP_N), .TMR_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .o_busy(o_busy),
    .o_cnt_en(o_cnt_en), .o_pair_sel(o_pair_sel), .i_valid_a(i_valid_a),
    .i_valid_b(i_valid_b), .o_resp(o_resp), .o_resp_valid(o_resp_valid),
    .i_resp_ready(i_resp_ready), .o_tie_err(o_tie_err), .o_timeout_err(o_timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compare each handshaken response with the queue head.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && o_resp_valid && i_resp_ready) begin
        hs_count++;
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_resp", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("resp", 32'(o_resp), 32'(mon_e.resp));
          chk("tie_err", 32'(o_tie_err), 32'(mon_e.tie));
          chk("timeout_err", 32'(o_timeout_err), 32'(mon_e.tout));
        end
      end
    end
  end

  // Enable-gap monitor: every low stretch between two races is GAP_N cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n || !o_busy) begin
        gap_seen_high = 1'b0;
        gap_run = 0;
      end else if (o_cnt_en) begin
        if (gap_seen_high && gap_run > 0) chk("gap_len", 32'(gap_run), 32'(GAP_N));
        gap_seen_high = 1'b1;
        gap_run = 0;
      end else if (gap_seen_high) begin
        gap_run++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic wait_en(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (o_cnt_en) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    chk("wait_cnt_en_timeout", 32'd0, 32'd1);
  endtask

  // Mode per race: 0 a first, 1 b first, 2 tie, 3 no valid (timeout).
  task automatic run_races(input logic [15:0] modes, output int exp_lat);
    bit ok;
    logic [1:0] m;
    int n;
    exp_lat = 1;
    for (int i = 0; i < 8; i++) begin
      m = modes[2*i +: 2];
      wait_en(ok);
      if (!ok) return;
      chk("pair_sel", 32'(o_pair_sel), 32'(i));
      if (m == 2'd3) begin
        n = 1;
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (!o_cnt_en) break;
          n++;
        end
        chk("arm_len_timeout", 32'(n), 32'(TMO_N));
        exp_lat += TMO_N + GAP_N;
      end else begin
        repeat (17) @(negedge clk);
        i_valid_a = (m == 2'd0) || (m == 2'd2);
        i_valid_b = (m == 2'd1) || (m == 2'd2);
        @(negedge clk);
        i_valid_a = 1'b0;
        i_valid_b = 1'b0;
        chk("arm_end_after_valid", 32'(o_cnt_en), 32'd0);
        @(negedge clk);
        @(negedge clk);
        // Late pulse from the losing counter lands in GAP.
        if (m == 2'd0) i_valid_b = 1'b1;
        else if (m == 2'd1) i_valid_a = 1'b1;
        @(negedge clk);
        i_valid_a = 1'b0;
        i_valid_b = 1'b0;
        exp_lat += 18 + GAP_N;
      end
    end
  endtask

  task automatic measure(input logic [15:0] modes, input logic [7:0] er,
                         input logic et, input logic eo);
    int sc;
    int lat;
    bit found;
    sb_q.push_back('{resp: er, tie: et, tout: eo});
    push_count++;
    @(negedge clk);
    i_start = 1'b1;
    sc = cyc;
    @(negedge clk);
    i_start = 1'b0;
    run_races(modes, lat);
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (o_resp_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("resp_valid_seen", 32'(found), 32'd1);
    chk("latency", 32'(cyc - sc), 32'(lat));
    if (i_resp_ready) begin
      @(negedge clk);
      chk("valid_drop", 32'(o_resp_valid), 32'd0);
      chk("busy_drop", 32'(o_busy), 32'd0);
      chk("hs_once", 32'(hs_count), 32'(push_count));
    end
  endtask

  initial begin
    bit ok;
    bit stable;
    logic [7:0] held;

    // T1: reset values
    #3 rst_n = 1'b0;
    #4;
    chk("rst_outputs", 32'({o_busy, o_cnt_en, o_pair_sel, o_resp, o_resp_valid,
                            o_tie_err, o_timeout_err}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // T1: reset in the middle of a race
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_en(ok);
    repeat (5) @(negedge clk);
    chk("midarm_busy", 32'(o_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midarm_reset", 32'({o_busy, o_cnt_en, o_pair_sel, o_resp, o_resp_valid,
                             o_tie_err, o_timeout_err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", 32'({o_busy, o_cnt_en, o_resp_valid}), 32'd0);

    // T2: win/lose, race 3 swapped
    measure(16'h0040, 8'hF7, 1'b0, 1'b0);
    // T3: tie on race 0
    measure(16'h0002, 8'hFE, 1'b1, 1'b0);
    // T4: timeout on race 5, tie flag cleared by the new start
    measure(16'h0C00, 8'hDF, 1'b0, 1'b1);

    // T5: backpressure with an ignored start
    i_resp_ready = 1'b0;
    measure(16'h0011, 8'hFA, 1'b0, 1'b0);
    held = o_resp;
    stable = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (k == 10) i_start = 1'b1;
      if (k == 11) i_start = 1'b0;
      if (o_resp !== held || !o_resp_valid || !o_busy || o_cnt_en) stable = 1'b0;
    end
    chk("t5_hold", 32'(stable), 32'd1);
    chk("t5_resp", 32'(o_resp), 32'h0000_00FA);
    i_resp_ready = 1'b1;
    @(negedge clk);
    chk("t5_idle_busy", 32'({o_busy, o_resp_valid}), 32'd0);
    chk("t5_resp_held", 32'(o_resp), 32'h0000_00FA);
    chk("t5_hs", 32'(hs_count), 32'(push_count));

    // T6: stray valids while idle
    @(negedge clk);
    i_valid_a = 1'b1;
    @(negedge clk);
    i_valid_a = 1'b0;
    i_valid_b = 1'b1;
    @(negedge clk);
    i_valid_a = 1'b1;
    @(negedge clk);
    i_valid_a = 1'b0;
    i_valid_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_state", 32'({o_busy, o_cnt_en, o_resp_valid}), 32'd0);
    chk("t6_resp", 32'(o_resp), 32'h0000_00FA);
    chk("t6_flags", 32'({o_tie_err, o_timeout_err}), 32'd0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("hs_total", 32'(hs_count), 32'(push_count));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
